// File: rtl/spi_clkgen_if.sv
// Control/status bundle between an SPI master controller and spi_clkgen.
// The controller drives the frame setup and handshakes; the clock generator returns SCLK and strobes.
interface spi_clkgen_if #(
  parameter int unsigned DIV_WIDTH = 8,
  parameter int unsigned CNT_WIDTH = 6
);
  logic [DIV_WIDTH-1:0] clk_div;
  logic                 cpol;
  logic                 cpha;
  logic [CNT_WIDTH-1:0] frame_bits;
  logic                 start;
  logic                 abort;
  logic                 sclk;
  logic                 shift_stb;
  logic                 sample_stb;
  logic                 busy;
  logic                 done;

  modport master (
    output clk_div, cpol, cpha, frame_bits, start, abort,
    input  sclk, shift_stb, sample_stb, busy, done
  );

  modport slave (
    input  clk_div, cpol, cpha, frame_bits, start, abort,
    output sclk, shift_stb, sample_stb, busy, done
  );
endinterface

// File: rtl/spi_clkgen.sv
// Programmable SPI serial-clock generator: divides PCLK into SCLK for all CPOL/CPHA modes
// and frames a programmable number of bits with registered shift/sample strobes.
module spi_clkgen #(
  parameter int unsigned DIV_WIDTH = 8,
  parameter int unsigned CNT_WIDTH = 6
) (
  input logic        PCLK,
  input logic        PRESETN,
  spi_clkgen_if.slave bus
);

  localparam logic [1:0] st_idle  = 2'd0;
  localparam logic [1:0] st_lead  = 2'd1;  // sclk at ~cpol_l, next toggle is a trailing edge
  localparam logic [1:0] st_trail = 2'd2;  // sclk at cpol_l, next toggle is a leading edge

  logic [1:0]           state_q, state_d;
  logic [DIV_WIDTH-1:0] div_l_q, div_l_d;
  logic [DIV_WIDTH-1:0] half_cnt_q, half_cnt_d;
  logic [CNT_WIDTH-1:0] bit_cnt_q, bit_cnt_d;
  logic                 cpol_l_q, cpol_l_d;
  logic                 cpha_l_q, cpha_l_d;
  logic                 sclk_q, sclk_d;
  logic                 shift_q, shift_d;
  logic                 sample_q, sample_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  always_comb begin
    state_d    = state_q;
    div_l_d    = div_l_q;
    half_cnt_d = half_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    cpol_l_d   = cpol_l_q;
    cpha_l_d   = cpha_l_q;
    sclk_d     = sclk_q;
    busy_d     = busy_q;
    shift_d    = 1'b0;
    sample_d   = 1'b0;
    done_d     = 1'b0;

    if (bus.abort) begin
      state_d = st_idle;
      busy_d  = 1'b0;
      sclk_d  = bus.cpol;
    end else begin
      unique case (state_q)
        st_idle: begin
          sclk_d = bus.cpol;
          if (bus.start && (bus.frame_bits != '0)) begin
            div_l_d    = bus.clk_div;
            cpol_l_d   = bus.cpol;
            cpha_l_d   = bus.cpha;
            half_cnt_d = bus.clk_div;
            bit_cnt_d  = bus.frame_bits;
            busy_d     = 1'b1;
            state_d    = st_trail;
          end
        end
        st_lead, st_trail: begin
          if (half_cnt_q == '0) begin
            half_cnt_d = div_l_q;
            sclk_d     = ~sclk_q;
            if (state_q == st_lead) begin
              bit_cnt_d = bit_cnt_q - CNT_WIDTH'(1);
              // Mode 0/2 preloads bit 0, so the final trailing edge has nothing to shift.
              if (cpha_l_q) sample_d = 1'b1;
              else          shift_d  = (bit_cnt_q != CNT_WIDTH'(1));
              if (bit_cnt_q == CNT_WIDTH'(1)) begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = st_idle;
              end else begin
                state_d = st_trail;
              end
            end else begin
              state_d = st_lead;
              if (cpha_l_q) shift_d  = 1'b1;
              else          sample_d = 1'b1;
            end
          end else begin
            half_cnt_d = half_cnt_q - DIV_WIDTH'(1);
          end
        end
        default: begin
          state_d = st_idle;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETN) begin
      state_q    <= st_idle;
      div_l_q    <= '0;
      half_cnt_q <= '0;
      bit_cnt_q  <= '0;
      cpol_l_q   <= 1'b0;
      cpha_l_q   <= 1'b0;
      sclk_q     <= 1'b0;
      shift_q    <= 1'b0;
      sample_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_l_q    <= div_l_d;
      half_cnt_q <= half_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      cpol_l_q   <= cpol_l_d;
      cpha_l_q   <= cpha_l_d;
      sclk_q     <= sclk_d;
      shift_q    <= shift_d;
      sample_q   <= sample_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.sclk       = sclk_q;
  assign bus.shift_stb  = shift_q;
  assign bus.sample_stb = sample_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule
